// File: rtl/vreg_read_collector.sv
`default_nettype none
// ============================================================================
// Module      : vreg_read_collector
// Description : Collects per-port vreg operands from banked read arbiters and
//               presents them as one bundle once every requested port is read.
// Revision    : 1.0 - initial release
// ============================================================================
module vreg_read_collector #(
    parameter int PORT_NUM       = 5,
    parameter int READ_BANK_PORT = 2,
    parameter int BANK_NUM       = 4,
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]                     in_addr,
    input  logic [PORT_NUM-1:0]                                     in_mask,
    output logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]                     vreg_addr,
    output logic [PORT_NUM-1:0]                                     vreg_read_select,
    input  logic [BANK_NUM-1:0][PORT_NUM-1:0]                       grant_sel,
    input  logic [BANK_NUM-1:0][READ_BANK_PORT-1:0][PORT_NUM-1:0]   grant_idx,
    input  logic [BANK_NUM-1:0][READ_BANK_PORT-1:0][DATA_WIDTH-1:0] bank_rdata,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [PORT_NUM-1:0][DATA_WIDTH-1:0]                     out_data
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]                                               r_state;
    logic [1:0]                                               w_state_nxt;
    logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]                      r_addr;
    logic [PORT_NUM-1:0]                                      r_mask;
    logic [PORT_NUM-1:0]                                      r_issued;
    logic [PORT_NUM-1:0]                                      r_captured;
    logic [BANK_NUM-1:0][READ_BANK_PORT-1:0][PORT_NUM-1:0]    r_grant_q;
    logic [BANK_NUM-1:0][READ_BANK_PORT-1:0][PORT_NUM-1:0]    w_grant_q_nxt;
    logic [PORT_NUM-1:0][DATA_WIDTH-1:0]                      r_data;

    logic [PORT_NUM-1:0] w_sel_seen;
    logic [PORT_NUM-1:0] w_sel_multi;
    logic [PORT_NUM-1:0] w_idx_seen;
    logic [PORT_NUM-1:0] w_idx_multi;
    logic [PORT_NUM-1:0] w_pending;
    logic [PORT_NUM-1:0] w_port_ok;
    logic [PORT_NUM-1:0] w_new_issue;
    logic [PORT_NUM-1:0] w_bad_port;
    logic                w_bad_grant;
    logic                w_accept;

    assign in_ready         = (r_state == c_IDLE) && !rst;
    assign out_valid        = (r_state == c_DONE) && !rst;
    assign vreg_addr        = r_addr;
    assign out_data         = r_data;
    assign vreg_read_select = (r_state == c_ISSUE) ? (r_issued | ~r_mask) : {PORT_NUM{1'b1}};
    assign w_accept         = in_valid && in_ready;

    // Per-port grant census: a port granted by more than one bank/read port
    // in the same cycle is treated as an illegal grant and dropped.
    always_comb begin
        w_sel_seen  = '0;
        w_sel_multi = '0;
        w_idx_seen  = '0;
        w_idx_multi = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (grant_sel[b][p]) begin
                    if (w_sel_seen[p]) w_sel_multi[p] = 1'b1;
                    w_sel_seen[p] = 1'b1;
                end
                for (int j = 0; j < READ_BANK_PORT; j++) begin
                    if (grant_idx[b][j][p]) begin
                        if (w_idx_seen[p]) w_idx_multi[p] = 1'b1;
                        w_idx_seen[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_pending   = ~vreg_read_select;
    assign w_port_ok   = w_pending & ~w_sel_multi & ~w_idx_multi;
    assign w_new_issue = w_sel_seen & w_port_ok;
    assign w_bad_port  = (w_sel_seen | w_idx_seen) & ~w_port_ok;
    assign w_bad_grant = |w_bad_port;

    always_comb begin
        w_grant_q_nxt = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int j = 0; j < READ_BANK_PORT; j++) begin
                w_grant_q_nxt[b][j] = grant_idx[b][j] & w_port_ok;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_mask == '0) ? c_DONE : c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (((r_issued | w_new_issue) & r_mask) == r_mask) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: w_state_nxt = c_DONE;
            c_DONE: begin
                if (out_ready) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_mask     <= '0;
            r_issued   <= '0;
            r_captured <= '0;
            r_grant_q  <= '0;
            r_data     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant_q <= w_grant_q_nxt;
            if (w_accept) begin
                r_addr     <= in_addr;
                r_mask     <= in_mask;
                r_issued   <= '0;
                r_captured <= '0;
                r_data     <= '0;
            end else begin
                if (r_state == c_ISSUE) begin
                    r_issued <= r_issued | w_new_issue;
                end
                // Read data lands one cycle after its grant; route it by the
                // registered one-hot grant.
                for (int p = 0; p < PORT_NUM; p++) begin
                    for (int b = 0; b < BANK_NUM; b++) begin
                        for (int j = 0; j < READ_BANK_PORT; j++) begin
                            if (r_grant_q[b][j][p]) begin
                                r_data[p]     <= bank_rdata[b][j];
                                r_captured[p] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_grant_legal: assert (!w_bad_grant)
                else $warning("vreg_read_collector: illegal grant ignored, ports %b", w_bad_port);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vreg_read_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_vreg_read_collector
// Description : Directed self-checking bench; the bench plays the arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vreg_read_collector;

    localparam int P  = 5;
    localparam int RB = 2;
    localparam int B  = 4;
    localparam int AW = 6;
    localparam int DW = 64;

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              in_valid;
    logic                              in_ready;
    logic [P-1:0][AW-1:0]              in_addr;
    logic [P-1:0]                      in_mask;
    logic [P-1:0][AW-1:0]              vreg_addr;
    logic [P-1:0]                      vreg_read_select;
    logic [B-1:0][P-1:0]               grant_sel;
    logic [B-1:0][RB-1:0][P-1:0]       grant_idx;
    logic [B-1:0][RB-1:0][DW-1:0]      bank_rdata;
    logic                              out_valid;
    logic                              out_ready;
    logic [P-1:0][DW-1:0]              out_data;
    logic [P-1:0][DW-1:0]              r_exp_data;
    logic [P-1:0][AW-1:0]              r_exp_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vreg_read_collector #(
        .PORT_NUM       (P),
        .READ_BANK_PORT (RB),
        .BANK_NUM       (B),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_addr          (in_addr),
        .in_mask          (in_mask),
        .vreg_addr        (vreg_addr),
        .vreg_read_select (vreg_read_select),
        .grant_sel        (grant_sel),
        .grant_idx        (grant_idx),
        .bank_rdata       (bank_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data)
    );

    task automatic check(input string tag, input logic [P*DW-1:0] obs, input logic [P*DW-1:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_grants();
        grant_sel = '0;
        grant_idx = '0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_mask    = '0;
        grant_sel  = '0;
        grant_idx  = '0;
        bank_rdata = '0;
        out_ready  = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_vrs", vreg_read_select, 5'b11111);
        check("rst_vreg_addr", vreg_addr, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // ---------------- full mask, all in bank 0, grants 2/2/1 ----------------
        for (int p = 0; p < P; p++) begin
            r_exp_addr[p] = AW'(p * 4);
            r_exp_data[p] = 64'hA5A5_0000_0000_0000 | 64'(p + 1);
        end
        in_addr  = r_exp_addr;
        in_mask  = 5'b11111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("a_in_ready_issue", in_ready, 0);
        check("a_vreg_addr", vreg_addr, r_exp_addr);
        check("a_vrs_0", vreg_read_select, 5'b00000);
        grant_sel[0]    = 5'b00011;
        grant_idx[0][0] = 5'b00001;
        grant_idx[0][1] = 5'b00010;
        tick();
        check("a_vrs_1", vreg_read_select, 5'b00011);
        check("a_out_valid_1", out_valid, 0);
        grant_sel[0]     = 5'b01100;
        grant_idx[0][0]  = 5'b00100;
        grant_idx[0][1]  = 5'b01000;
        bank_rdata[0][0] = r_exp_data[0];
        bank_rdata[0][1] = r_exp_data[1];
        tick();
        check("a_vrs_2", vreg_read_select, 5'b01111);
        check("a_out_valid_2", out_valid, 0);
        grant_sel[0]     = 5'b10000;
        grant_idx[0][0]  = 5'b10000;
        grant_idx[0][1]  = 5'b00000;
        bank_rdata[0][0] = r_exp_data[2];
        bank_rdata[0][1] = r_exp_data[3];
        tick();
        check("a_drain_vrs", vreg_read_select, 5'b11111);
        check("a_drain_out_valid", out_valid, 0);
        clr_grants();
        bank_rdata[0][0] = r_exp_data[4];
        bank_rdata[0][1] = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        check("a_done_out_valid", out_valid, 1);
        check("a_done_out_data", out_data, r_exp_data);

        // ---------------- back-pressure in DONE ----------------
        for (int k = 0; k < 4; k++) begin
            bank_rdata = {B*RB{64'hBAD0_BAD0_0000_0000 | 64'(k)}};
            in_valid   = 1'b1;
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, r_exp_data);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("a_release_out_valid", out_valid, 0);
        check("a_release_in_ready", in_ready, 1);

        // ---------------- sparse mask, three banks in one cycle ----------------
        r_exp_addr = '0;
        r_exp_addr[0] = 6'd1;
        r_exp_addr[1] = 6'd5;
        r_exp_addr[2] = 6'd2;
        r_exp_addr[3] = 6'd6;
        r_exp_addr[4] = 6'd3;
        in_addr  = r_exp_addr;
        in_mask  = 5'b10101;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b_vrs_issue", vreg_read_select, 5'b01010);
        grant_sel[1]    = 5'b00001;
        grant_sel[2]    = 5'b00100;
        grant_sel[3]    = 5'b10000;
        grant_idx[1][0] = 5'b00001;
        grant_idx[2][1] = 5'b00100;
        grant_idx[3][0] = 5'b10000;
        tick();
        check("b_drain_out_valid", out_valid, 0);
        check("b_drain_vrs", vreg_read_select, 5'b11111);
        clr_grants();
        bank_rdata       = {B*RB{64'h7777_7777_7777_7777}};
        bank_rdata[1][0] = 64'h1111_0000_0000_0000;
        bank_rdata[2][1] = 64'h2222_0000_0000_0000;
        bank_rdata[3][0] = 64'h4444_0000_0000_0000;
        r_exp_data    = '0;
        r_exp_data[0] = 64'h1111_0000_0000_0000;
        r_exp_data[2] = 64'h2222_0000_0000_0000;
        r_exp_data[4] = 64'h4444_0000_0000_0000;
        tick();
        check("b_done_out_valid", out_valid, 1);
        check("b_done_out_data", out_data, r_exp_data);
        tick();
        check("b_release_in_ready", in_ready, 1);

        // ---------------- empty mask ----------------
        in_mask  = 5'b00000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("c_out_valid", out_valid, 1);
        check("c_vrs", vreg_read_select, 5'b11111);
        check("c_out_data", out_data, 0);
        tick();
        check("c_release_out_valid", out_valid, 0);

        // ---------------- reset during ISSUE ----------------
        in_addr  = '0;
        in_mask  = 5'b00011;
        in_valid = 1'b1;
        tick();
        in_valid        = 1'b0;
        grant_sel[0]    = 5'b00001;
        grant_idx[0][0] = 5'b00001;
        tick();
        clr_grants();
        rst        = 1'b1;
        bank_rdata = {B*RB{64'h1A7E_1A7E_1A7E_1A7E}};
        tick();
        check("d_rst_in_ready", in_ready, 0);
        check("d_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        check("d_in_ready", in_ready, 1);
        check("d_out_data", out_data, 0);
        check("d_captured", dut.r_captured, 0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("d_no_out_valid", out_valid, 0);
        end

        // ---------------- illegal grant on an issued port ----------------
        out_ready  = 1'b1;
        bank_rdata = '0;
        in_mask    = 5'b00011;
        in_valid   = 1'b1;
        tick();
        in_valid        = 1'b0;
        grant_sel[0]    = 5'b00001;
        grant_idx[0][0] = 5'b00001;
        tick();
        clr_grants();
        grant_sel[1]     = 5'b00001;
        grant_idx[1][0]  = 5'b00001;
        bank_rdata[0][0] = 64'hF0F0_0000_0000_0000;
        #1;
        check("e_bad_grant_flag", dut.w_bad_grant, 1);
        tick();
        check("e_issued", dut.r_issued, 5'b00001);
        check("e_captured", dut.r_captured, 5'b00001);
        clr_grants();
        grant_sel[1]     = 5'b00010;
        grant_idx[1][1]  = 5'b00010;
        bank_rdata[0][0] = '0;
        bank_rdata[1][0] = 64'hBADB_ADBA_DBAD_BADB;
        tick();
        check("e_captured_after", dut.r_captured, 5'b00001);
        check("e_vrs_drain", vreg_read_select, 5'b11111);
        clr_grants();
        bank_rdata[1][0] = '0;
        bank_rdata[1][1] = 64'hF1F1_0000_0000_0000;
        r_exp_data    = '0;
        r_exp_data[0] = 64'hF0F0_0000_0000_0000;
        r_exp_data[1] = 64'hF1F1_0000_0000_0000;
        tick();
        check("e_done_out_valid", out_valid, 1);
        check("e_done_out_data", out_data, r_exp_data);
        tick();
        check("e_release_in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
